r_ctrl: RTL

Central write-side controller of the 1x4 router.
- Decodes the header destination and sequences header/payload/parity writes into the four output FIFOs.
- Stalls the source on FIFO-full or busy destination.
- Generates per-FIFO valid flags and soft-reset timeouts when an output port leaves data unread.
- Sits between the input register/parity block and the four FIFO instances.

---
 rtl/r_pkg.sv | 79 +++++++
 rtl/r_if.sv | 45 ++++
 rtl/r_sr_timer.sv | 46 ++++
 rtl/r_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/r_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : r_pkg
//  Purpose  : Shared types and defaults for the router write-side controller.
//  Revision : 1.0 - initial release
// ============================================================================
package r_pkg;

    localparam int NUM_PORTS = 4;
    localparam int TIMEOUT   = 30;
    localparam int CNT_W     = 5;
    localparam int ADDR_W    = 2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } r_state_t;

    typedef struct packed {
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic laf_state;
        logic full_state;
        logic rst_int_reg;
        logic busy;
        logic write_enb_reg;
    } r_flags_t;

    // Moore output decode shared by reset and run-time paths.
    function automatic r_flags_t decode_flags(input r_state_t st);
        r_flags_t f;
        f = '0;
        case (st)
            DECODE_ADDRESS: begin
                f.detect_add = 1'b1;
            end
            LOAD_FIRST_DATA: begin
                f.lfd_state     = 1'b1;
                f.busy          = 1'b1;
                f.write_enb_reg = 1'b1;
            end
            LOAD_DATA: begin
                f.ld_state      = 1'b1;
                f.write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                f.full_state = 1'b1;
                f.busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                f.laf_state     = 1'b1;
                f.busy          = 1'b1;
                f.write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                f.busy          = 1'b1;
                f.write_enb_reg = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                f.rst_int_reg = 1'b1;
                f.busy        = 1'b1;
            end
            WAIT_TILL_EMPTY: begin
                f.busy = 1'b1;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/r_if.sv
`default_nettype none
// ============================================================================
//  Module   : r_if
//  Purpose  : Source, register-block and FIFO-side signals of the controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface r_if;
    import r_pkg::*;

    logic                 pkt_valid;
    logic [7:0]           data_in;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] read_enb;
    logic                 parity_done;
    logic                 low_pkt_valid;

    logic [NUM_PORTS-1:0] write_enb;
    logic                 write_enb_reg;
    logic                 detect_add;
    logic                 lfd_state;
    logic                 ld_state;
    logic                 laf_state;
    logic                 full_state;
    logic                 rst_int_reg;
    logic                 busy;
    logic [NUM_PORTS-1:0] vld_out;
    logic [NUM_PORTS-1:0] soft_reset;

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
               parity_done, low_pkt_valid,
        output write_enb, write_enb_reg, detect_add, lfd_state, ld_state,
               laf_state, full_state, rst_int_reg, busy, vld_out, soft_reset
    );

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
               parity_done, low_pkt_valid,
        input  write_enb, write_enb_reg, detect_add, lfd_state, ld_state,
               laf_state, full_state, rst_int_reg, busy, vld_out, soft_reset
    );

endinterface
`default_nettype wire

// File: rtl/r_sr_timer.sv
`default_nettype none
// ============================================================================
//  Module   : r_sr_timer
//  Purpose  : Per-port unread-data timer producing a one-cycle soft reset.
//  Revision : 1.0 - initial release
// ============================================================================
module r_sr_timer #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic resetn,
    input  logic vld,
    input  logic read_enb,
    output logic soft_reset
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_soft_reset;
    logic             w_idle;

    assign w_idle = vld && !read_enb;

    // Counter restarts on the firing edge so it never exceeds c_last.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b0;
        end else if (w_idle && (r_cnt == c_last)) begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b1;
        end else if (w_idle) begin
            r_cnt        <= r_cnt + CNT_W'(1);
            r_soft_reset <= 1'b0;
        end else begin
            r_cnt        <= '0;
            r_soft_reset <= 1'b0;
        end
    end

    assign soft_reset = r_soft_reset;

endmodule
`default_nettype wire

// File: rtl/r_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : r_ctrl
//  Purpose  : Router write-side FSM, address latch, write decode and timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module r_ctrl #(
    parameter int TIMEOUT = r_pkg::TIMEOUT,
    parameter int CNT_W   = r_pkg::CNT_W
) (
    input  logic clk,
    input  logic resetn,
    r_if.slave   bus
);
    import r_pkg::*;

    r_state_t             r_state;
    r_state_t             w_next;
    r_flags_t             r_flags;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W-1:0]    w_hdr_addr;
    logic [NUM_PORTS-1:0] w_vld;
    logic [NUM_PORTS-1:0] w_soft_reset;
    logic [NUM_PORTS-1:0] w_write_enb;
    logic                 w_unused_data;

    assign w_hdr_addr    = bus.data_in[ADDR_W-1:0];
    assign w_unused_data = ^bus.data_in[7:ADDR_W];
    assign w_vld         = ~bus.fifo_empty;

    always_comb begin
        w_next = r_state;
        case (r_state)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    w_next = bus.fifo_empty[w_hdr_addr] ? LOAD_FIRST_DATA
                                                        : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: w_next = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full[r_addr])
                    w_next = FIFO_FULL_STATE;
                else if (!bus.pkt_valid)
                    w_next = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full[r_addr])
                    w_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)
                    w_next = DECODE_ADDRESS;
                else if (bus.low_pkt_valid)
                    w_next = LOAD_PARITY;
                else
                    w_next = LOAD_DATA;
            end
            LOAD_PARITY: w_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                w_next = bus.fifo_full[r_addr] ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (bus.fifo_empty[r_addr])
                    w_next = LOAD_FIRST_DATA;
            end
            default: w_next = DECODE_ADDRESS;
        endcase
        // A timeout on the active destination abandons the packet outright.
        if ((r_state != DECODE_ADDRESS) && w_soft_reset[r_addr])
            w_next = DECODE_ADDRESS;
    end

    // Flags are registered from the next state so they track r_state exactly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DECODE_ADDRESS;
            r_flags <= decode_flags(DECODE_ADDRESS);
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            r_flags <= decode_flags(w_next);
            if ((r_state == DECODE_ADDRESS) && bus.pkt_valid)
                r_addr <= w_hdr_addr;
        end
    end

    always_comb begin
        w_write_enb = '0;
        if (r_flags.write_enb_reg)
            w_write_enb[r_addr] = 1'b1;
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timer
        r_sr_timer #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_timer (
            .clk        (clk),
            .resetn     (resetn),
            .vld        (w_vld[g]),
            .read_enb   (bus.read_enb[g]),
            .soft_reset (w_soft_reset[g])
        );
    end

    assign bus.write_enb     = w_write_enb;
    assign bus.write_enb_reg = r_flags.write_enb_reg;
    assign bus.detect_add    = r_flags.detect_add;
    assign bus.lfd_state     = r_flags.lfd_state;
    assign bus.ld_state      = r_flags.ld_state;
    assign bus.laf_state     = r_flags.laf_state;
    assign bus.full_state    = r_flags.full_state;
    assign bus.rst_int_reg   = r_flags.rst_int_reg;
    assign bus.busy          = r_flags.busy;
    assign bus.vld_out       = w_vld;
    assign bus.soft_reset    = w_soft_reset;

endmodule
`default_nettype wire
